// File: rtl/kuznechik_apb_wrapper.sv
// APB3/APB4 register front-end for the Kuznechik block cipher, including the iterative cipher core.
// Optional macro KUZ_APB_WAIT_STATE_EN adds one registered wait state to every APB transfer.

module kuznechik_cipher (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         request_i,
  input  logic         ack_i,
  input  logic [127:0] data_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [127:0] data_o
);

  localparam int PI [256] = '{
    252, 238, 221,  17, 207, 110,  49,  22, 251, 196, 250, 218,  35, 197,   4,  77,
    233, 119, 240, 219, 147,  46, 153, 186,  23,  54, 241, 187,  20, 205,  95, 193,
    249,  24, 101,  90, 226,  92, 239,  33, 129,  28,  60,  66, 139,   1, 142,  79,
      5, 132,   2, 174, 227, 106, 143, 160,   6,  11, 237, 152, 127, 212, 211,  31,
    235,  52,  44,  81, 234, 200,  72, 171, 242,  42, 104, 162, 253,  58, 206, 204,
    181, 112,  14,  86,   8,  12, 118,  18, 191, 114,  19,  71, 156, 183,  93, 135,
     21, 161, 150,  41,  16, 123, 154, 199, 243, 145, 120, 111, 157, 158, 178, 177,
     50, 117,  25,  61, 255,  53, 138, 126, 109,  84, 198, 128, 195, 189,  13,  87,
    223, 245,  36, 169,  62, 168,  67, 201, 215, 121, 214, 246, 124,  34, 185,   3,
    224,  15, 236, 222, 122, 148, 176, 188, 220, 232,  40,  80,  78,  51,  10,  74,
    167, 151,  96, 115,  30,   0,  98,  68,  26, 184,  56, 130, 100, 159,  38,  65,
    173,  69,  70, 146,  39,  94,  85,  47, 140, 163, 165, 125, 105, 213, 149,  59,
      7,  88, 179,  64, 134, 172,  29, 247,  48,  55, 107, 228, 136, 217, 231, 137,
    225,  27, 131,  73,  76,  63, 248, 254, 141,  83, 170, 144, 202, 216, 133,  97,
     32, 113, 103, 164,  45,  43,   9,  91, 203, 155,  37, 208, 190, 229, 108,  82,
     89, 166, 116, 210, 230, 244, 180, 192, 209, 102, 175, 194,  57,  75,  99, 182
  };

  // Pre-expanded round keys of the fixed device key.
  localparam logic [127:0] RKEY [10] = '{
    128'h8899aabbccddeeff0011223344556677,
    128'hfedcba98765432100123456789abcdef,
    128'hdb31485315694343228d6aef8cc78c44,
    128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'h57646468c44a5e28d3e59246f429f1ac,
    128'hbd079435165c6432b532e82834da581b,
    128'h51e640757e8745de705727265a0098b1,
    128'h5a7925017b9fdd3ed72a91a22286f984,
    128'hbb44e25378c73123a5f32f73cdb6e517,
    128'h72e9dd7416bcf45b755dbaa88e4a4043
  };

  // Linear-feedback coefficient applied to byte j of the block.
  localparam logic [7:0] LCOEF [16] = '{
    8'd1, 8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1,
    8'd251, 8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148
  };

  typedef enum logic [1:0] {ST_IDLE, ST_SX, ST_LIN, ST_DONE} kuz_state_t;

  kuz_state_t   state_q, state_d;
  logic [3:0]   round_q, step_q;
  logic [127:0] blk_q;
  logic         last_step, last_round;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'hC3 : 8'h00);
    end
    return acc;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] y;
    int           v;
    y = '0;
    for (int i = 0; i < 16; i++) begin
      v = PI[x[8*i +: 8]];
      y[8*i +: 8] = v[7:0];
    end
    return y;
  endfunction

  function automatic logic [127:0] r_step(input logic [127:0] x);
    logic [7:0] l;
    l = '0;
    for (int j = 0; j < 16; j++) l = l ^ gf_mul(x[8*j +: 8], LCOEF[j]);
    return {l, x[127:8]};
  endfunction

  assign last_step  = (step_q == 4'd15);
  assign last_round = (round_q == 4'd8);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (request_i) state_d = ST_SX;
      ST_SX:   state_d = ST_LIN;
      ST_LIN:  if (last_step) state_d = last_round ? ST_DONE : ST_SX;
      ST_DONE: if (ack_i) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      round_q <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: round_q <= '0;
        ST_SX:   step_q  <= '0;
        ST_LIN: begin
          step_q <= step_q + 4'd1;
          if (last_step) round_q <= round_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Round datapath: one S-box cycle, then sixteen R steps; the final key is folded into the last R step.
  always_ff @(posedge clk_i) begin
    case (state_q)
      ST_IDLE: if (request_i) blk_q <= data_i;
      ST_SX:   blk_q <= sub_bytes(blk_q ^ RKEY[round_q]);
      ST_LIN:  blk_q <= (last_step && last_round) ? (r_step(blk_q) ^ RKEY[9]) : r_step(blk_q);
      default: ;
    endcase
  end

  assign busy_o  = (state_q == ST_SX) || (state_q == ST_LIN);
  assign valid_o = (state_q == ST_DONE);
  assign data_o  = blk_q;

endmodule

module kuznechik_apb_wrapper (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  input  logic [3:0]  PSTRB,
  output logic        PREADY,
  output logic [31:0] PRDATA,
  output logic        PSLVERR
);

  logic             access, xfer_done, wr_ok;
  logic             mapped, is_ctrl, is_din, is_dout;
  logic [3:0]       word_idx;
  logic [1:0]       sub_idx;
  logic             req_ack_wr, rst_next, err_c;
  logic [31:0]      rdata_c, ctrl_word;
  logic [3:0][31:0] din_q;
  logic [3:0][31:0] dout_words;
  logic             rst_q, req_q, ack_q;
  logic             core_busy, core_valid, core_resetn;
  logic [127:0]     core_dout;

  assign access   = PSEL & PENABLE;
  assign mapped   = (PADDR[1:0] == 2'b00) && (PADDR <= 32'h20);
  assign word_idx = PADDR[5:2];
  // Words 1..4 and 5..8 both map to index 0..3 by subtracting one from the low two bits.
  assign sub_idx  = word_idx[1:0] - 2'd1;
  assign is_ctrl  = mapped && (word_idx == 4'd0);
  assign is_din   = mapped && (word_idx >= 4'd1) && (word_idx <= 4'd4);
  assign is_dout  = mapped && (word_idx >= 4'd5);

  assign req_ack_wr = PSTRB[1] & PWDATA[8];
  assign rst_next   = PSTRB[0] ? PWDATA[0] : rst_q;
  assign ctrl_word  = {7'b0, core_busy, 7'b0, core_valid, 8'b0, 7'b0, rst_q};
  assign dout_words = core_dout;

  always_comb begin
    rdata_c = '0;
    if (!PWRITE && mapped) begin
      if (is_ctrl)     rdata_c = ctrl_word;
      else if (is_din) rdata_c = din_q[sub_idx];
      else             rdata_c = dout_words[sub_idx];
    end
  end

  always_comb begin
    err_c = !mapped;
    if (PWRITE) begin
      err_c = !mapped || is_dout
           || (is_ctrl && (PSTRB[2] || PSTRB[3] || (req_ack_wr && core_busy)))
           || (is_din && core_busy);
    end
  end

`ifdef KUZ_APB_WAIT_STATE_EN
  logic        pready_q, pslverr_q;
  logic [31:0] prdata_q;

  // Response is captured in the first access cycle and presented in the second.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else if (access && !pready_q) begin
      pready_q  <= 1'b1;
      pslverr_q <= err_c;
      prdata_q  <= rdata_c;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;
`else
  assign PREADY  = access;
  assign PSLVERR = access & err_c;
  assign PRDATA  = access ? rdata_c : '0;
`endif

  assign xfer_done = access & PREADY;
  // The reported error decides the discard, so both stay consistent in wait-state mode.
  assign wr_ok     = xfer_done & PWRITE & ~PSLVERR;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      din_q <= '0;
      rst_q <= 1'b1;
      req_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      req_q <= 1'b0;
      ack_q <= 1'b0;
      if (wr_ok && is_ctrl) begin
        rst_q <= rst_next;
        if (req_ack_wr && rst_next) begin
          if (core_valid) ack_q <= 1'b1;
          else            req_q <= 1'b1;
        end
      end
      if (wr_ok && is_din) begin
        for (int b = 0; b < 4; b++) begin
          if (PSTRB[b]) din_q[sub_idx][8*b +: 8] <= PWDATA[8*b +: 8];
        end
      end
    end
  end

  assign core_resetn = PRESETn & rst_q;

  kuznechik_cipher u_core (
    .clk_i     (PCLK),
    .resetn_i  (core_resetn),
    .request_i (req_q),
    .ack_i     (ack_q),
    .data_i    (din_q),
    .busy_o    (core_busy),
    .valid_o   (core_valid),
    .data_o    (core_dout)
  );

endmodule

// File: tb/tb_kuznechik_apb_wrapper.sv
// Directed self-checking bench for kuznechik_apb_wrapper with a behavioural cipher reference.
module tb_kuznechik_apb_wrapper;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic [31:0] PADDR;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic        PREADY;
  logic [31:0] PRDATA;
  logic        PSLVERR;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] rd;
  logic        er;

  localparam logic [31:0] DIN [4] = '{32'hB1F05663, 32'h8484D609, 32'hC0895E81, 32'h12153524};

  localparam int TPI [256] = '{
    252, 238, 221,  17, 207, 110,  49,  22, 251, 196, 250, 218,  35, 197,   4,  77,
    233, 119, 240, 219, 147,  46, 153, 186,  23,  54, 241, 187,  20, 205,  95, 193,
    249,  24, 101,  90, 226,  92, 239,  33, 129,  28,  60,  66, 139,   1, 142,  79,
      5, 132,   2, 174, 227, 106, 143, 160,   6,  11, 237, 152, 127, 212, 211,  31,
    235,  52,  44,  81, 234, 200,  72, 171, 242,  42, 104, 162, 253,  58, 206, 204,
    181, 112,  14,  86,   8,  12, 118,  18, 191, 114,  19,  71, 156, 183,  93, 135,
     21, 161, 150,  41,  16, 123, 154, 199, 243, 145, 120, 111, 157, 158, 178, 177,
     50, 117,  25,  61, 255,  53, 138, 126, 109,  84, 198, 128, 195, 189,  13,  87,
    223, 245,  36, 169,  62, 168,  67, 201, 215, 121, 214, 246, 124,  34, 185,   3,
    224,  15, 236, 222, 122, 148, 176, 188, 220, 232,  40,  80,  78,  51,  10,  74,
    167, 151,  96, 115,  30,   0,  98,  68,  26, 184,  56, 130, 100, 159,  38,  65,
    173,  69,  70, 146,  39,  94,  85,  47, 140, 163, 165, 125, 105, 213, 149,  59,
      7,  88, 179,  64, 134, 172,  29, 247,  48,  55, 107, 228, 136, 217, 231, 137,
    225,  27, 131,  73,  76,  63, 248, 254, 141,  83, 170, 144, 202, 216, 133,  97,
     32, 113, 103, 164,  45,  43,   9,  91, 203, 155,  37, 208, 190, 229, 108,  82,
     89, 166, 116, 210, 230, 244, 180, 192, 209, 102, 175, 194,  57,  75,  99, 182
  };

  localparam logic [127:0] TKEY [10] = '{
    128'h8899aabbccddeeff0011223344556677, 128'hfedcba98765432100123456789abcdef,
    128'hdb31485315694343228d6aef8cc78c44, 128'h3d4553d8e9cfec6815ebadc40a9ffd04,
    128'h57646468c44a5e28d3e59246f429f1ac, 128'hbd079435165c6432b532e82834da581b,
    128'h51e640757e8745de705727265a0098b1, 128'h5a7925017b9fdd3ed72a91a22286f984,
    128'hbb44e25378c73123a5f32f73cdb6e517, 128'h72e9dd7416bcf45b755dbaa88e4a4043
  };

  // l() coefficients listed from a15 (most significant byte) down to a0.
  localparam int LHI [16] = '{148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1};

  always #5 PCLK = ~PCLK;

  kuznechik_apb_wrapper dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PADDR   (PADDR),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PWDATA  (PWDATA),
    .PSTRB   (PSTRB),
    .PREADY  (PREADY),
    .PRDATA  (PRDATA),
    .PSLVERR (PSLVERR)
  );

  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--) if (p[k]) p = p ^ (15'h1C3 << (k - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
    logic [127:0] s;
    logic [7:0]   l;
    int           v, c;
    s = pt;
    for (int r = 0; r < 9; r++) begin
      s = s ^ TKEY[r];
      for (int i = 0; i < 16; i++) begin
        v = TPI[s[8*i +: 8]];
        s[8*i +: 8] = v[7:0];
      end
      for (int n = 0; n < 16; n++) begin
        l = '0;
        for (int j = 15; j >= 0; j--) begin
          c = LHI[15 - j];
          l = l ^ ref_mul(s[8*j +: 8], c[7:0]);
        end
        s = {l, s[127:8]};
      end
    end
    return s ^ TKEY[9];
  endfunction

  task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdata, output logic err);
    int wait_cnt;
    @(posedge PCLK); #1;
    PADDR = a; PWDATA = d; PSTRB = s; PWRITE = wr; PSEL = 1'b1; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #1;
    wait_cnt = 0;
    while (PREADY !== 1'b1 && wait_cnt < 8) begin
      @(posedge PCLK); #2;
      wait_cnt++;
    end
    rdata = PRDATA;
    err   = PSLVERR;
    if (PREADY !== 1'b1) begin
      tests_run++;
      tests_failed++;
      $display("FAIL apb_timeout addr=%h: PREADY=%b required 1", a, PREADY);
      err = 1'bx;
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PSTRB = 4'h0;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic err);
    logic [31:0] unused_rd;
    apb_xfer(1'b1, a, d, s, unused_rd, err);
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] data, output logic err);
    apb_xfer(1'b0, a, 32'h0, 4'h0, data, err);
  endtask

  task automatic load_block(input logic [127:0] blk);
    for (int k = 0; k < 4; k++) begin
      apb_write(32'h4 + 32'(4 * k), blk[32*k +: 32], 4'hF, er);
      tests_run++;
      if (er !== 1'b0) begin tests_failed++; $display("FAIL load_err w%0d: got %b required 0", k, er); end
    end
  endtask

  task automatic wait_valid(input string tag);
    int polls;
    polls = 0;
    rd = '0;
    while (rd[16] !== 1'b1 && polls < 400) begin
      apb_read(32'h0, rd, er);
      polls++;
    end
    tests_run++;
    if (rd !== 32'h00010001) begin
      tests_failed++;
      $display("FAIL %s_valid_ctrl: got %h required 00010001 after %0d polls", tag, rd, polls);
    end
  endtask

  task automatic check_result(input logic [127:0] pt, input string tag);
    logic [127:0] exp;
    exp = ref_encrypt(pt);
    for (int k = 0; k < 4; k++) begin
      apb_read(32'h14 + 32'(4 * k), rd, er);
      tests_run++;
      if (rd !== exp[32*k +: 32] || er !== 1'b0) begin
        tests_failed++;
        $display("FAIL %s_dout w%0d: got %h err %b required %h err 0", tag, k, rd, er, exp[32*k +: 32]);
      end
    end
  endtask

  task automatic ack_and_check(input string tag);
    apb_write(32'h0, 32'h00000101, 4'b0011, er);
    tests_run++;
    if (er !== 1'b0) begin tests_failed++; $display("FAIL %s_ack_err: got %b required 0", tag, er); end
    apb_read(32'h0, rd, er);
    tests_run++;
    if (rd !== 32'h00000001) begin tests_failed++; $display("FAIL %s_after_ack: got %h required 00000001", tag, rd); end
  endtask

  task automatic start_request(input string tag);
    apb_write(32'h0, 32'h00000101, 4'b0011, er);
    tests_run++;
    if (er !== 1'b0) begin tests_failed++; $display("FAIL %s_req_err: got %b required 0", tag, er); end
  endtask

  task automatic test_reset();
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0;
    repeat (5) @(posedge PCLK);
    #1;
    tests_run++;
    if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got rdy=%b err=%b rdata=%h required 0 0 0", PREADY, PSLVERR, PRDATA);
    end
    PRESETn = 1'b1;
    apb_read(32'h0, rd, er);
    tests_run++;
    if (rd !== 32'h00000001 || er !== 1'b0) begin
      tests_failed++; $display("FAIL reset_ctrl: got %h err %b required 00000001 err 0", rd, er);
    end
    for (int k = 0; k < 4; k++) begin
      apb_read(32'h4 + 32'(4 * k), rd, er);
      tests_run++;
      if (rd !== 32'h0 || er !== 1'b0) begin
        tests_failed++; $display("FAIL reset_din w%0d: got %h err %b required 0", k, rd, er);
      end
    end
  endtask

  task automatic test_registers();
    apb_write(32'h0, 32'h000000FF, 4'b0011, er);
    tests_run++;
    if (er !== 1'b0) begin tests_failed++; $display("FAIL ctrl_ff_err: got %b required 0", er); end
    apb_read(32'h0, rd, er);
    tests_run++;
    if (rd !== 32'h00000001) begin tests_failed++; $display("FAIL ctrl_ff_read: got %h required 00000001", rd); end
    for (int k = 0; k < 4; k++) begin
      apb_write(32'h4 + 32'(4 * k), DIN[k], 4'hF, er);
      tests_run++;
      if (er !== 1'b0) begin tests_failed++; $display("FAIL din_wr_err w%0d: got %b required 0", k, er); end
    end
    for (int k = 0; k < 4; k++) begin
      apb_read(32'h4 + 32'(4 * k), rd, er);
      tests_run++;
      if (rd !== DIN[k] || er !== 1'b0) begin
        tests_failed++; $display("FAIL din_rd w%0d: got %h err %b required %h err 0", k, rd, er, DIN[k]);
      end
    end
    apb_write(32'h4, 32'hAAAAAAAA, 4'b0101, er);
    apb_read(32'h4, rd, er);
    tests_run++;
    if (rd !== 32'hB1AA56AA) begin tests_failed++; $display("FAIL din_strobe: got %h required B1AA56AA", rd); end
    apb_write(32'h4, DIN[0], 4'hF, er);
  endtask

  task automatic test_errors();
    logic [31:0] bad_addr [7];
    bad_addr = '{32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h02, 32'h1000_0004};
    apb_write(32'h0, 32'h00000000, 4'b1100, er);
    tests_run++;
    if (er !== 1'b1) begin tests_failed++; $display("FAIL err_ctrl_1100: got %b required 1", er); end
    apb_write(32'h0, 32'h00000000, 4'b1111, er);
    tests_run++;
    if (er !== 1'b1) begin tests_failed++; $display("FAIL err_ctrl_1111: got %b required 1", er); end
    apb_read(32'h0, rd, er);
    tests_run++;
    if (rd !== 32'h00000001) begin tests_failed++; $display("FAIL err_ctrl_kept: got %h required 00000001", rd); end
    for (int k = 0; k < 7; k++) begin
      apb_write(bad_addr[k], 32'h00000000, 4'hF, er);
      tests_run++;
      if (er !== 1'b1) begin tests_failed++; $display("FAIL err_write addr=%h: got %b required 1", bad_addr[k], er); end
    end
    for (int k = 0; k < 4; k++) begin
      apb_read(32'h4 + 32'(4 * k), rd, er);
      tests_run++;
      if (rd !== DIN[k]) begin tests_failed++; $display("FAIL err_din_kept w%0d: got %h required %h", k, rd, DIN[k]); end
    end
    apb_read(32'h24, rd, er);
    tests_run++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      tests_failed++; $display("FAIL err_read_0x24: got %h err %b required 0 err 1", rd, er);
    end
    apb_read(32'h20, rd, er);
    tests_run++;
    if (er !== 1'b0) begin tests_failed++; $display("FAIL read_dout_noerr: got %b required 0", er); end
  endtask

  task automatic test_encrypt();
    logic [127:0] pt;
    pt = 128'h3ee5c99f9a41c389ac17b4fe99c72ae4;
    load_block(pt);
    start_request("enc");
    apb_read(32'h0, rd, er);
    tests_run++;
    if (rd !== 32'h01000001) begin tests_failed++; $display("FAIL enc_busy: got %h required 01000001", rd); end
    wait_valid("enc");
    check_result(pt, "enc");
    check_result(pt, "enc_stable");
    ack_and_check("enc");
  endtask

  task automatic test_double_request();
    logic [127:0] pt;
    pt = 128'h00112233445566778899aabbccddeeff;
    load_block(pt);
    start_request("dbl");
    apb_write(32'h0, 32'h00000101, 4'b0011, er);
    tests_run++;
    if (er !== 1'b1) begin tests_failed++; $display("FAIL dbl_second_req: got %b required 1", er); end
    apb_write(32'h4, 32'hDEADBEEF, 4'hF, er);
    tests_run++;
    if (er !== 1'b1) begin tests_failed++; $display("FAIL dbl_din_busy: got %b required 1", er); end
    apb_read(32'h4, rd, er);
    tests_run++;
    if (rd !== pt[31:0]) begin tests_failed++; $display("FAIL dbl_din_kept: got %h required %h", rd, pt[31:0]); end
    apb_read(32'h0, rd, er);
    tests_run++;
    if (rd !== 32'h01000001) begin tests_failed++; $display("FAIL dbl_still_busy: got %h required 01000001", rd); end
    wait_valid("dbl");
    check_result(pt, "dbl");
    ack_and_check("dbl");
  endtask

  task automatic test_reset_abort();
    logic [127:0] pt;
    pt = 128'hfedcba9876543210f0e1d2c3b4a59687;
    start_request("abort");
    apb_write(32'h0, 32'h00000000, 4'b0001, er);
    tests_run++;
    if (er !== 1'b0) begin tests_failed++; $display("FAIL abort_rst_err: got %b required 0", er); end
    apb_read(32'h0, rd, er);
    tests_run++;
    if (rd !== 32'h00000000) begin tests_failed++; $display("FAIL abort_ctrl: got %h required 00000000", rd); end
    apb_read(32'h10, rd, er);
    tests_run++;
    if (rd !== 32'h00112233) begin tests_failed++; $display("FAIL abort_din_kept: got %h required 00112233", rd); end
    load_block(pt);
    apb_write(32'h0, 32'h00000100, 4'b0011, er);
    apb_write(32'h0, 32'h00000001, 4'b0001, er);
    apb_read(32'h0, rd, er);
    tests_run++;
    if (rd !== 32'h00000001) begin tests_failed++; $display("FAIL reset_wins: got %h required 00000001", rd); end
    apb_write(32'h0, 32'h00000000, 4'b0001, er);
    start_request("restart");
    apb_read(32'h0, rd, er);
    tests_run++;
    if (rd !== 32'h01000001) begin tests_failed++; $display("FAIL restart_busy: got %h required 01000001", rd); end
    wait_valid("restart");
    check_result(pt, "restart");
    ack_and_check("restart");
  endtask

  initial begin
    test_reset();
    test_registers();
    test_errors();
    test_encrypt();
    test_double_request();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/kuznechik_apb_wrapper.md
Name: kuznechik_apb_wrapper

Overview:
APB3/APB4 slave that wraps the existing Kuznechik (GOST R 34.12-2015) block-cipher core `kuznechik_cipher`, instantiated inside this block, for memory-mapped use. Software:
- loads a 128-bit plaintext into four DATA_IN words;
- starts encryption through the CONTROL register;
- polls VALID;
- reads four DATA_OUT words;
- acknowledges.

The cipher rounds and key schedule live in the core. This block is only the register file, access checking and handshake glue.

Parameters:
None. Address map and widths are fixed.

Ports:
- PCLK  in  1  APB clock; also clocks the cipher core.
- PRESETn  in  1  asynchronous active-low reset.
- PADDR  in  32  byte address.
- PSEL  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1=write, 0=read.
- PWDATA  in  32  write data.
- PSTRB  in  4  byte write strobes.
- PREADY  out  1  transfer complete.
- PRDATA  out  32  read data.
- PSLVERR  out  1  transfer error, valid when PREADY=1.

Behaviour:
Core interface (fixed):
- Inputs: clk_i, resetn_i, request_i, ack_i, data_i[127:0].
- Outputs: busy_o, valid_o, data_o[127:0].
- Core resetn_i = PRESETn & RST.

Address map (word-aligned; 32-bit word w at byte offset 4w):
- 0x00 CONTROL.
  - byte0 bit0 = RST, R/W; 0 holds the core in reset.
  - byte1 bit0 = REQ_ACK, write-1 pulse, reads 0.
  - byte2 bit0 = VALID, RO, from valid_o.
  - byte3 bit0 = BUSY, RO, from busy_o.
  - All other bits read 0, writes to them are ignored.
- 0x04,0x08,0x0C,0x10 DATA_IN words 0..3, R/W. Word k = data_i[32k+31:32k].
- 0x14,0x18,0x1C,0x20 DATA_OUT words 0..3, RO. Word k = data_o[32k+31:32k].

Reset (PRESETn=0):
- DATA_IN = 0; RST = 1; request/ack pulses = 0.
- PREADY = 0; PSLVERR = 0; PRDATA = 0.

Timing:
- Zero wait states: PREADY = PSEL & PENABLE, combinational.
- PRDATA and PSLVERR are combinational during the access phase.
- Register updates happen on the PCLK edge that completes the access (PSEL & PENABLE & PREADY).
- Byte writes honour PSTRB.

PSLVERR=1 conditions; the whole write is discarded, no partial update:
- PADDR[1:0] != 0.
- PADDR > 0x20.
- Write to DATA_OUT.
- Write to CONTROL with PSTRB[2] or PSTRB[3] set.
- Write to CONTROL with PSTRB[1]=1, PWDATA[8]=1 while BUSY=1; a second request while encrypting is an error.
- Write to DATA_IN while BUSY=1.

Reads of any mapped address never error. PRDATA = 0 on an erroring read.

REQ_ACK write (PSTRB[1]=1, PWDATA[8]=1, no error):
- Generates a one-cycle pulse on the next cycle.
- Pulse drives ack_i if VALID=1, else request_i.
- If the same write sets RST=0, reset wins and no pulse is issued.

RST:
- Writing 0 immediately resets the core, so BUSY and VALID read 0 on the next access.
- DATA_IN keeps its contents and stays writable while RST=0.
- Writing 1 releases the core.

VALID stays 1 until acked. DATA_OUT is stable while VALID=1.

Optional Feature:
Macro KUZ_APB_WAIT_STATE_EN.
- Defined: every transfer gets exactly one wait state. PREADY is registered: low in the first access cycle, high in the second. PRDATA and PSLVERR are registered and valid with PREADY. Register updates occur at PREADY completion.
- Undefined: zero-wait-state behaviour as above.

Test Plan:
- PRESETn low 5 cycles, then:
  - read CONTROL -> 0x00000001;
  - read DATA_IN words -> 0.
- Write CONTROL 0x000000FF with PSTRB=0011. Then write DATA_IN = {0x12153524,0xC0895E81,0x8484D609,0xB1F05663} with PSTRB=1111 and read it back -> identical, PSLVERR=0 throughout.
- Error cases, each -> PSLVERR=1 and registers unchanged:
  - write CONTROL with PSTRB=1100;
  - write DATA_OUT words 0x14..0x20;
  - write 0x24;
  - write 0x02.
- Encrypt 128'h3ee5c99f9a41c389ac17b4fe99c72ae4:
  - write DATA_IN;
  - write CONTROL 0x00000101 -> BUSY=1;
  - poll until VALID=1;
  - read DATA_OUT -> equals core reference model output;
  - write 0x00000101 -> VALID=0.
- After a request, immediately write CONTROL 0x00000101 -> PSLVERR=1, encryption continues, result still correct and ackable.
- After a request, write CONTROL 0x00000000 with PSTRB=0001 -> subsequent reads give VALID=0 and BUSY=0. Then write RST=1 with REQ_ACK -> new encryption completes normally.
